// File: rtl/demux_sc.sv
// demux_sc: 1-to-2 valid/ready stream demux with a 2-deep FIFO per channel and x-aware select
module demux_sc #(
  parameter int SIZE  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SIZE-1:0]  in_i,
  input  logic             sel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [SIZE-1:0]  out_a_o,
  output logic             out_a_valid_o,
  input  logic             out_a_ready_i,
  output logic [SIZE-1:0]  out_b_o,
  output logic             out_b_valid_o,
  input  logic             out_b_ready_i,
  output logic             sel_err_o,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o,
  output logic [CNT_W-1:0] err_cnt_o
);
  logic [1:0][SIZE-1:0]  h_q, h_d, t_q, t_d;
  logic [1:0][1:0]       n_q, n_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]      err_q, err_d;
  logic                  sel_err_q;
  logic                  sel_bad, acc, drop;
  logic [1:0]            rdy, push, pop;
  // Classify the select, gate acceptance and compute next state of both FIFOs and counters
  always_comb begin
    sel_bad    = !(sel_i === 1'b0 || sel_i === 1'b1);
    in_ready_o = !rst_i && (sel_bad || (sel_i ? n_q[1] != 2'd2 : n_q[0] != 2'd2));
    acc        = in_valid_i && in_ready_o;
    drop       = acc && sel_bad;
    push       = {acc && !sel_bad && sel_i, acc && !sel_bad && !sel_i};
    rdy        = {out_b_ready_i, out_a_ready_i};
    for (int c = 0; c < 2; c++) begin
      pop[c]   = n_q[c] != 2'd0 && rdy[c];
      h_d[c]   = (pop[c] && n_q[c] == 2'd2) ? t_q[c] :
                 (push[c] && (n_q[c] == 2'd0 || pop[c])) ? in_i : h_q[c];
      t_d[c]   = (push[c] && n_q[c] == 2'd1 && !pop[c]) ? in_i : t_q[c];
      n_d[c]   = n_q[c] + 2'(push[c]) - 2'(pop[c]);
      cnt_d[c] = cnt_q[c] + CNT_W'(push[c]);
    end
    err_d = err_q + CNT_W'(drop && err_q != '1);
  end
  // FIFO storage, occupancy, counters and the one-cycle drop pulse; reset flushes everything
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      h_q       <= '0;
      t_q       <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      t_q       <= t_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      sel_err_q <= drop;
    end
  assign out_a_o       = h_q[0];
  assign out_b_o       = h_q[1];
  assign out_a_valid_o = n_q[0] != 2'd0;
  assign out_b_valid_o = n_q[1] != 2'd0;
  assign cnt_a_o       = cnt_q[0];
  assign cnt_b_o       = cnt_q[1];
  assign err_cnt_o     = err_q;
  assign sel_err_o     = sel_err_q;
endmodule
